// File: rtl/bc_pkg.sv
// Shared definitions for the Bulls-and-Cows engine: key codes, game states
// and the counter-width helper used to size port widths.
package bc_pkg;

    localparam logic [3:0] KEY_BS    = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_SCORE,
        ST_WON,
        ST_LOST
    } state_t;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bc_entry_buffer.sv
// Guess entry buffer: left-justified digit store with backspace, entry count
// and a repeated-digit detector over the full buffer.
module bc_entry_buffer
    import bc_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    localparam int CW         = count_width(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    push,
    input  logic [3:0]              push_digit,
    input  logic                    pop,
    output logic [4*NUM_DIGITS-1:0] guess,
    output logic [CW-1:0]           digit_cnt,
    output logic                    full,
    output logic                    has_dup
);

    logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    assign full      = (cnt_q == CW'(NUM_DIGITS));
    assign guess     = buf_q;
    assign digit_cnt = cnt_q;

    always_comb begin
        // NOTE: every comb-assigned signal gets a default first so no path leaves it unassigned (no latch).
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clear) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (push && !full) begin
            for (int p = 0; p < NUM_DIGITS; p++) begin
                if (cnt_q == CW'(p)) buf_d[4*(NUM_DIGITS-1-p) +: 4] = push_digit;
            end
            cnt_d = cnt_q + CW'(1);
        end else if (pop && cnt_q != '0) begin
            for (int p = 0; p < NUM_DIGITS; p++) begin
                if (cnt_q == CW'(p + 1)) buf_d[4*(NUM_DIGITS-1-p) +: 4] = 4'd0;
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        has_dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (buf_q[4*i +: 4] == buf_q[4*j +: 4]) has_dup = 1'b1;
            end
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows game engine: keypad entry, one-position-per-cycle strike/ball
// scoring, attempt counting and win/lose outcome.
module bulls_cows_engine
    import bc_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int MAX_TRIES  = 10,
    parameter  bit ALLOW_DUP  = 1'b0,
    localparam int CW         = count_width(NUM_DIGITS),
    localparam int TW         = count_width(MAX_TRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    new_game,
    input  logic [4*NUM_DIGITS-1:0] answer,
    output logic [4*NUM_DIGITS-1:0] guess,
    output logic [CW-1:0]           digit_cnt,
    output logic [CW-1:0]           strike,
    output logic [CW-1:0]           ball,
    output logic                    result_valid,
    output logic                    dup_err,
    output logic                    answer_err,
    output logic [TW-1:0]           tries_used,
    output logic                    busy,
    output logic                    win,
    output logic                    lose
);

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] ans_q, ans_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           s_acc_q, s_acc_d, b_acc_q, b_acc_d;
    logic [CW-1:0]           strike_q, strike_d, ball_q, ball_d;
    logic [TW-1:0]           tries_q, tries_d;
    logic                    result_valid_q, result_valid_d;
    logic                    dup_err_q, dup_err_d;
    logic                    answer_err_q, answer_err_d;

    logic                    answer_ok;
    logic                    in_entry, key_digit, key_bs, key_enter;
    logic                    buf_push, buf_pop, buf_clear, buf_full, buf_dup;
    logic                    enter_full, dup_reject, start_score, score_last;
    logic [3:0]              cur_g, cur_a;
    logic                    strike_hit, ball_hit, in_other;
    logic [CW-1:0]           s_next, b_next;
    logic [TW-1:0]           tries_inc;

    always_comb begin
        answer_ok = 1'b1;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (answer[4*p +: 4] > 4'd9) answer_ok = 1'b0;
        end
    end

    // new_game overrides everything, so entry-side actions are all masked by it.
    assign in_entry    = (state_q == ST_ENTRY) && !new_game;
    assign key_digit   = key_valid && (key_code <= 4'd9);
    assign key_bs      = key_valid && (key_code == KEY_BS);
    assign key_enter   = key_valid && (key_code == KEY_ENTER);
    assign buf_push    = in_entry && key_digit;
    assign buf_pop     = in_entry && key_bs;
    assign enter_full  = in_entry && key_enter && buf_full;
    assign dup_reject  = enter_full && !ALLOW_DUP && buf_dup;
    assign start_score = enter_full && !dup_reject;
    assign score_last  = (state_q == ST_SCORE) && (idx_q == CW'(NUM_DIGITS - 1));
    assign buf_clear   = new_game || dup_reject || score_last;

    bc_entry_buffer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_entry (
        .clk        (clk),
        .rst        (rst),
        .clear      (buf_clear),
        .push       (buf_push),
        .push_digit (key_code),
        .pop        (buf_pop),
        .guess      (guess),
        .digit_cnt  (digit_cnt),
        .full       (buf_full),
        .has_dup    (buf_dup)
    );

    // Per-position compare for the digit currently being scored.
    always_comb begin
        cur_g    = 4'd0;
        cur_a    = 4'd0;
        in_other = 1'b0;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (idx_q == CW'(p)) begin
                cur_g = guess[4*(NUM_DIGITS-1-p) +: 4];
                cur_a = ans_q[4*(NUM_DIGITS-1-p) +: 4];
            end
        end
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx_q != CW'(j) && ans_q[4*(NUM_DIGITS-1-j) +: 4] == cur_g) in_other = 1'b1;
        end
    end

    assign strike_hit = (cur_g == cur_a);
    assign ball_hit   = !strike_hit && in_other;
    assign s_next     = s_acc_q + CW'(strike_hit);
    assign b_next     = b_acc_q + CW'(ball_hit);
    assign tries_inc  = tries_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = answer_ok ? ST_ENTRY : ST_IDLE;
        end else begin
            case (state_q)
                ST_ENTRY: if (start_score) state_d = ST_SCORE;
                ST_SCORE: begin
                    if (score_last) begin
                        if (s_next == CW'(NUM_DIGITS))          state_d = ST_WON;
                        else if (tries_inc == TW'(MAX_TRIES))   state_d = ST_LOST;
                        else                                    state_d = ST_ENTRY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_SCORE);
        win  = (state_q == ST_WON);
        lose = (state_q == ST_LOST);
    end

    always_comb begin
        ans_d          = ans_q;
        idx_d          = idx_q;
        s_acc_d        = s_acc_q;
        b_acc_d        = b_acc_q;
        strike_d       = strike_q;
        ball_d         = ball_q;
        tries_d        = tries_q;
        result_valid_d = 1'b0;
        dup_err_d      = 1'b0;
        answer_err_d   = 1'b0;
        if (new_game) begin
            ans_d        = answer_ok ? answer : '0;
            answer_err_d = !answer_ok;
            idx_d        = '0;
            s_acc_d      = '0;
            b_acc_d      = '0;
            strike_d     = '0;
            ball_d       = '0;
            tries_d      = '0;
        end else begin
            if (start_score) begin
                idx_d   = '0;
                s_acc_d = '0;
                b_acc_d = '0;
            end
            if (state_q == ST_SCORE) begin
                idx_d   = idx_q + CW'(1);
                s_acc_d = s_next;
                b_acc_d = b_next;
                if (score_last) begin
                    strike_d       = s_next;
                    ball_d         = b_next;
                    tries_d        = tries_inc;
                    result_valid_d = 1'b1;
                end
            end
            dup_err_d = dup_reject;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ans_q          <= '0;
            idx_q          <= '0;
            s_acc_q        <= '0;
            b_acc_q        <= '0;
            strike_q       <= '0;
            ball_q         <= '0;
            tries_q        <= '0;
            result_valid_q <= 1'b0;
            dup_err_q      <= 1'b0;
            answer_err_q   <= 1'b0;
        end else begin
            ans_q          <= ans_d;
            idx_q          <= idx_d;
            s_acc_q        <= s_acc_d;
            b_acc_q        <= b_acc_d;
            strike_q       <= strike_d;
            ball_q         <= ball_d;
            tries_q        <= tries_d;
            result_valid_q <= result_valid_d;
            dup_err_q      <= dup_err_d;
            answer_err_q   <= answer_err_d;
        end
    end

    assign strike       = strike_q;
    assign ball         = ball_q;
    assign tries_used   = tries_q;
    assign result_valid = result_valid_q;
    assign dup_err      = dup_err_q;
    assign answer_err   = answer_err_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed bench for bulls_cows_engine (4 digits, 3 tries, duplicates rejected)
// with hand-computed expected values checked by immediate assertions.
module tb_bulls_cows_engine;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          new_game;
    logic [4*N-1:0] answer;
    logic [4*N-1:0] guess;
    logic [CW-1:0] digit_cnt, strike, ball;
    logic          result_valid, dup_err, answer_err, busy, win, lose;
    logic [TW-1:0] tries_used;

    int n_checks = 0;
    int n_fail   = 0;

    bulls_cows_engine #(
        .NUM_DIGITS (4),
        .MAX_TRIES  (3),
        .ALLOW_DUP  (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .new_game     (new_game),
        .answer       (answer),
        .guess        (guess),
        .digit_cnt    (digit_cnt),
        .strike       (strike),
        .ball         (ball),
        .result_valid (result_valid),
        .dup_err      (dup_err),
        .answer_err   (answer_err),
        .tries_used   (tries_used),
        .busy         (busy),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic start_game(input logic [4*N-1:0] ans);
        answer   = ans;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Called in the cycle after enter was sampled; waits (bounded) for result_valid.
    task automatic wait_result(output int lat, output int busy_cycles);
        lat         = 1;
        busy_cycles = 0;
        while (!result_valid && lat < 20) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic enter_guess(input logic [3:0] d0, d1, d2, d3);
        press(d0);
        press(d1);
        press(d2);
        press(d3);
        press(4'd11);
    endtask

    int lat, bc, rv_seen;

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        new_game  = 1'b0;
        answer    = 16'h1234;

        // 1. reset, then keys while IDLE
        tick();
        press(4'd5);
        rst = 1'b0;
        press(4'd1);
        press(4'd11);
        check("idle_guess", guess, 0);
        check("idle_digit_cnt", digit_cnt, 0);
        check("idle_strike_ball", {strike, ball}, 0);
        check("idle_flags", {result_valid, dup_err, answer_err, busy, win, lose}, 0);
        check("idle_tries", tries_used, 0);

        // 2. first guess 1329 vs 1234 -> 1 strike, 2 balls
        start_game(16'h1234);
        check("ng_answer_err", answer_err, 0);
        press(4'd1);
        press(4'd3);
        press(4'd2);
        press(4'd9);
        check("entry_guess", guess, 16'h1329);
        check("entry_cnt", digit_cnt, 4);
        press(4'd11);
        check("score_busy_first", busy, 1);
        wait_result(lat, bc);
        check("result_latency", lat, 5);
        check("busy_cycles", bc, 4);
        check("g1_busy_after", busy, 0);
        check("g1_strike", strike, 1);
        check("g1_ball", ball, 2);
        check("g1_tries", tries_used, 1);
        check("g1_guess_cleared", {guess, 13'(digit_cnt)}, 0);
        tick();
        check("result_valid_pulse", result_valid, 0);
        check("g1_strike_held", strike, 1);

        // 3. backspace underflow and overflow digit ignored, then a win
        press(4'd5);
        press(4'd6);
        press(4'd10);
        press(4'd10);
        press(4'd10);
        check("bs_underflow_cnt", digit_cnt, 0);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        press(4'd5);
        check("overflow_guess", guess, 16'h1234);
        check("overflow_cnt", digit_cnt, 4);
        press(4'd11);
        wait_result(lat, bc);
        check("g2_strike", strike, 4);
        check("g2_ball", ball, 0);
        check("g2_win", {win, lose}, 2'b10);
        check("g2_tries", tries_used, 2);
        press(4'd7);
        press(4'd11);
        tick();
        check("won_keys_ignored", {13'(digit_cnt), busy, win}, 1);

        // 4. duplicate-digit guess rejected
        start_game(16'h1234);
        check("ng_clears_win", {win, 2'(tries_used)}, 0);
        enter_guess(4'd1, 4'd1, 4'd2, 4'd3);
        check("dup_err_pulse", dup_err, 1);
        check("dup_cnt_cleared", digit_cnt, 0);
        check("dup_no_busy", busy, 0);
        rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (result_valid) rv_seen++;
        end
        check("dup_err_one_cycle", dup_err, 0);
        check("dup_no_result", rv_seen, 0);
        check("dup_tries", tries_used, 0);

        // 5. three misses -> LOST
        for (int g = 1; g <= 3; g++) begin
            enter_guess(4'd5, 4'd6, 4'd7, 4'd8);
            wait_result(lat, bc);
            check("miss_strike_ball", {strike, ball}, 0);
            check("miss_tries", tries_used, g);
            check("miss_lose", lose, (g == 3) ? 1 : 0);
        end
        press(4'd1);
        check("lost_keys_ignored", digit_cnt, 0);

        // 6. invalid answer aborts an in-flight score
        start_game(16'h1234);
        check("ng_clears_lose", lose, 0);
        enter_guess(4'd1, 4'd2, 4'd3, 4'd4);
        tick();
        check("abort_in_score", busy, 1);
        answer   = 16'h12A4;
        new_game = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd7;
        tick();
        new_game  = 1'b0;
        key_valid = 1'b0;
        check("answer_err_pulse", answer_err, 1);
        check("abort_state", {busy, win, lose}, 0);
        check("abort_tries", tries_used, 0);
        check("abort_cnt", digit_cnt, 0);
        rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (result_valid) rv_seen++;
        end
        check("abort_no_result", rv_seen, 0);
        check("answer_err_one_cycle", answer_err, 0);
        press(4'd3);
        check("bad_answer_idle", digit_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
